// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_ctrl interrupt controller: register
// offsets as a function of the source count, the spurious vector and the
// fixed-priority pick used on acknowledge.
package irq_ctrl_pkg;

    // Vector returned when an acknowledge finds nothing pending and enabled.
    localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

    // Largest supported source count (the pick works on a 16-bit request).
    localparam int MAX_SRC = 12;

    // Result of the priority pick: valid plus winning source index.
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } prio_t;

    // Divider register for source i sits at address i.
    function automatic int div_base(input int i);
        return i;
    endfunction

    // Enable mask (low 8 sources).
    function automatic int en_ofs(input int nsrc);
        return nsrc;
    endfunction

    // Vector base register.
    function automatic int base_ofs(input int nsrc);
        return nsrc + 1;
    endfunction

    // Write-1-to-clear pending bits (low 8 sources).
    function automatic int clr_ofs(input int nsrc);
        return nsrc + 2;
    endfunction

    // End-of-interrupt strobe; also carries enable [3:0] and clear [7:4]
    // for sources 8 and up when more than 8 sources are configured.
    function automatic int eoi_ofs(input int nsrc);
        return nsrc + 3;
    endfunction

    // Lowest set index wins.
    function automatic prio_t prio_pick(input logic [15:0] req);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_rate_div.sv
// One interrupt source: rising-edge detect, rate divider and pending flag.
// The divider counts enabled edges and fires on the edge where the count has
// reached the programmed divide value, so div=N fires every (N+1)th edge.
// A fire and a clear in the same cycle leave the flag set.
module irq_rate_div
    import irq_ctrl_pkg::*;
#(
    parameter int DIVW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            src,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    input  logic            clr,
    output logic            pending
);

    logic            src_d;
    logic [DIVW-1:0] cnt;
    logic            src_edge;
    logic            fire;

    assign src_edge = src & ~src_d;
    // >= rather than == so lowering div below the running count fires next.
    assign fire     = src_edge & en & (cnt >= div);

    // Edge history, divide counter and pending flag; reset seeds the history
    // with the live level so a source held high does not fire on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_d   <= src;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            src_d <= src;
            if (src_edge && en) begin
                if (cnt >= div) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (fire) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority Z80 interrupt controller for NSRC level event sources.
// Each source has its own rate divider and enable; pending flags drive a
// registered active-low int_n.  On the rising edge of iack the lowest
// enabled pending source wins, its vector (base + 2*index) is latched onto
// vec and its pending flag is cleared.
//
// Handshake: there is no valid/ready pair.  iack is a level from the CPU;
// only its rising edge (iack & ~iack_d) counts as one acknowledge.  vec is
// valid from the cycle after that edge until the next acknowledge edge.
//
// Optional build macro IRQ_CTRL_STATUS_EN adds the status output and the
// end-of-interrupt register; without it that address is ignored.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int DIVW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_addr,
    input  logic [7:0]      cfg_data,
    input  logic            iack,
    output logic            int_n,
    output logic [7:0]      vec
`ifdef IRQ_CTRL_STATUS_EN
    ,
    output logic [7:0]      status
`endif
);

    localparam int EN_OFS   = en_ofs(NSRC);
    localparam int BASE_OFS = base_ofs(NSRC);
    localparam int CLR_OFS  = clr_ofs(NSRC);
    localparam int EOI_OFS  = eoi_ofs(NSRC);

    logic [DIVW-1:0] div_q [NSRC];
    logic [NSRC-1:0] en_q;
    logic [7:0]      base_q;
    logic            iack_d;
    logic            ack_edge;

    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] active;
    logic [15:0]     active_pad;
    prio_t           pick;

    logic [NSRC-1:0] en_sel;
    logic [NSRC-1:0] en_val;
    logic [NSRC-1:0] cfg_clr;
    logic [NSRC-1:0] ack_clr;

    assign ack_edge   = iack & ~iack_d;
    assign active     = pending & en_q;
    assign active_pad = 16'(active);
    assign pick       = prio_pick(active_pad);

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        // Sources 0..7 live in the low registers, 8 and up in the high one.
        localparam int EN_ADDR  = (i < 8) ? EN_OFS  : EOI_OFS;
        localparam int EN_BIT   = (i < 8) ? i       : i - 8;
        localparam int CLR_ADDR = (i < 8) ? CLR_OFS : EOI_OFS;
        localparam int CLR_BIT  = (i < 8) ? i       : i - 4;

        assign en_sel[i]  = cfg_we && (cfg_addr == 4'(EN_ADDR));
        assign en_val[i]  = cfg_data[EN_BIT];
        assign cfg_clr[i] = cfg_we && (cfg_addr == 4'(CLR_ADDR)) && cfg_data[CLR_BIT];
        assign ack_clr[i] = ack_edge && pick.valid && (pick.idx == 4'(i));

        irq_rate_div #(
            .DIVW (DIVW)
        ) u_div (
            .clk     (clk),
            .reset   (reset),
            .src     (src[i]),
            .en      (en_q[i]),
            .div     (div_q[i]),
            .clr     (ack_clr[i] | cfg_clr[i]),
            .pending (pending[i])
        );
    end

    // Configuration registers; an acknowledge in the same cycle as a write
    // sees the old values because it reads these registers directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                div_q[i] <= '0;
            end
            en_q   <= '0;
            base_q <= 8'h00;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (cfg_we && (cfg_addr == 4'(div_base(i)))) begin
                    div_q[i] <= cfg_data[DIVW-1:0];
                end
                if (en_sel[i]) begin
                    en_q[i] <= en_val[i];
                end
            end
            if (cfg_we && (cfg_addr == 4'(BASE_OFS))) begin
                base_q <= cfg_data;
            end
        end
    end

    // Request line, acknowledge edge history and latched vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            iack_d <= iack;
            int_n  <= 1'b1;
            vec    <= SPURIOUS_VEC;
        end else begin
            iack_d <= iack;
            int_n  <= ~|active;
            if (ack_edge) begin
                if (pick.valid) begin
                    vec <= base_q + {3'b000, pick.idx, 1'b0};
                end else begin
                    vec <= SPURIOUS_VEC;
                end
            end
        end
    end

`ifdef IRQ_CTRL_STATUS_EN
    logic       in_service_valid;
    logic [2:0] w_last;

    // In-service tracking: set by a real acknowledge, cleared by EOI.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_service_valid <= 1'b0;
            w_last           <= 3'd0;
        end else begin
            if (ack_edge && pick.valid) begin
                in_service_valid <= 1'b1;
                w_last           <= pick.idx[2:0];
            end else if (cfg_we && (cfg_addr == 4'(EOI_OFS))) begin
                in_service_valid <= 1'b0;
            end
        end
    end

    assign status = {in_service_valid, w_last, active_pad[3:0]};
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the interrupt rules.
module tb_irq_ctrl;

    localparam int NSRC = 4;
    localparam int DIVW = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       iack;
    logic       int_n;
    logic [7:0] vec;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    irq_ctrl #(
        .NSRC (NSRC),
        .DIVW (DIVW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .src      (src),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .iack     (iack),
        .int_n    (int_n),
        .vec      (vec)
    );

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_en;
    logic [3:0] m_pend;
    logic [3:0] m_src_prev;
    int         m_div [4];
    int         m_cnt [4];
    logic [7:0] m_base;
    logic [7:0] m_vec;
    logic       m_iack_prev;
    logic       m_int_n;

    task automatic model_reset();
        m_en   = 4'h0;
        m_pend = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_div[i] = 0;
            m_cnt[i] = 0;
        end
        m_base      = 8'h00;
        m_vec       = 8'hFF;
        m_int_n     = 1'b1;
        m_src_prev  = src;
        m_iack_prev = iack;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs now driven, then let
    // the DUT take the same edge and compare.
    task automatic tick();
        logic       ack;
        logic       nxt_int_n;
        logic [3:0] clr;
        logic       fire;
        int         w;
        if (reset) begin
            model_reset();
        end else begin
            nxt_int_n = ((m_pend & m_en) == 4'h0);
            ack = iack && !m_iack_prev;
            clr = 4'h0;
            if (ack) begin
                w = -1;
                for (int i = 3; i >= 0; i--) begin
                    if (m_pend[i] && m_en[i]) w = i;
                end
                if (w >= 0) begin
                    m_vec = 8'((int'(m_base) + 2 * w) % 256);
                    clr[w] = 1'b1;
                end else begin
                    m_vec = 8'hFF;
                end
                exp_q.push_back(m_vec);
            end
            if (cfg_we && cfg_addr == 4'd6) clr = clr | cfg_data[3:0];
            for (int i = 0; i < 4; i++) begin
                fire = 1'b0;
                if (src[i] && !m_src_prev[i] && m_en[i]) begin
                    if (m_cnt[i] >= m_div[i]) begin
                        m_cnt[i] = 0;
                        fire = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                if (fire) m_pend[i] = 1'b1;
                else if (clr[i]) m_pend[i] = 1'b0;
            end
            if (cfg_we) begin
                if (cfg_addr < 4'd4) m_div[cfg_addr] = int'(cfg_data[DIVW-1:0]);
                else if (cfg_addr == 4'd4) m_en = cfg_data[3:0];
                else if (cfg_addr == 4'd5) m_base = cfg_data;
            end
            m_src_prev  = src;
            m_iack_prev = iack;
            m_int_n     = nxt_int_n;
        end
        @(posedge clk);
        #1;
        check("int_n", {7'b0, int_n}, {7'b0, m_int_n});
        if (exp_q.size() > 0) check("ack_vec", vec, exp_q.pop_front());
        else check("vec_hold", vec, m_vec);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        src = src | m;
        tick();
        src = src & ~m;
        tick();
    endtask

    task automatic do_ack();
        iack = 1'b1;
        tick();
        iack = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        src      = 4'h0;
        cfg_we   = 1'b0;
        cfg_addr = 4'h0;
        cfg_data = 8'h00;
        iack     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_int_n", {7'b0, int_n}, 8'h01);
        check("rst_vec", vec, 8'hFF);

        // Basic fire
        cfg_wr(4'd4, 8'h01);
        cfg_wr(4'd0, 8'h00);
        cfg_wr(4'd5, 8'h40);
        src = 4'h1;
        tick();
        check("basic_latency", {7'b0, int_n}, 8'h01);
        src = 4'h0;
        tick();
        check("basic_int", {7'b0, int_n}, 8'h00);
        iack = 1'b1;
        tick();
        check("basic_vec", vec, 8'h40);
        iack = 1'b0;
        tick();
        check("basic_release", {7'b0, int_n}, 8'h01);

        // Divider: every 8th edge
        cfg_wr(4'd0, 8'd7);
        for (int k = 0; k < 7; k++) pulse(4'h1);
        check("div7_quiet", {7'b0, int_n}, 8'h01);
        pulse(4'h1);
        check("div7_fire", {7'b0, int_n}, 8'h00);
        do_ack();
        // Divider: every 64th edge
        cfg_wr(4'd0, 8'd63);
        for (int k = 0; k < 63; k++) pulse(4'h1);
        check("div63_quiet", {7'b0, int_n}, 8'h01);
        pulse(4'h1);
        check("div63_fire", {7'b0, int_n}, 8'h00);
        do_ack();
        // Lowering div below the running count
        cfg_wr(4'd0, 8'd7);
        for (int k = 0; k < 5; k++) pulse(4'h1);
        check("lower_quiet", {7'b0, int_n}, 8'h01);
        cfg_wr(4'd0, 8'd2);
        pulse(4'h1);
        check("lower_fire", {7'b0, int_n}, 8'h00);
        do_ack();

        // Priority
        cfg_wr(4'd4, 8'h0F);
        cfg_wr(4'd5, 8'h80);
        pulse(4'b1010);
        iack = 1'b1;
        tick();
        check("prio_first", vec, 8'h82);
        iack = 1'b0;
        tick();
        check("prio_still", {7'b0, int_n}, 8'h00);
        iack = 1'b1;
        tick();
        check("prio_second", vec, 8'h86);
        iack = 1'b0;
        tick();
        check("prio_done", {7'b0, int_n}, 8'h01);

        // Spurious acknowledge
        iack = 1'b1;
        tick();
        check("spurious_vec", vec, 8'hFF);
        iack = 1'b0;
        tick();

        // Mask and re-enable
        pulse(4'h4);
        check("mask_pend", {7'b0, int_n}, 8'h00);
        cfg_wr(4'd4, 8'h0B);
        tick();
        check("mask_off", {7'b0, int_n}, 8'h01);
        cfg_wr(4'd4, 8'h0F);
        tick();
        check("mask_on", {7'b0, int_n}, 8'h00);
        do_ack();
        check("mask_ack_vec", vec, 8'h84);

        // Event in the same clock as its acknowledge clear
        cfg_wr(4'd0, 8'h00);
        pulse(4'h1);
        src  = 4'h1;
        iack = 1'b1;
        tick();
        check("coll_vec", vec, 8'h80);
        src  = 4'h0;
        iack = 1'b0;
        tick();
        tick();
        check("coll_ack_keep", {7'b0, int_n}, 8'h00);
        do_ack();
        check("coll_release", {7'b0, int_n}, 8'h01);
        // Config clear and event on the same bit
        src      = 4'h2;
        cfg_we   = 1'b1;
        cfg_addr = 4'd6;
        cfg_data = 8'h02;
        tick();
        cfg_we = 1'b0;
        src    = 4'h0;
        tick();
        tick();
        check("coll_clr_keep", {7'b0, int_n}, 8'h00);
        cfg_wr(4'd6, 8'h0F);
        tick();
        check("cfg_clr_done", {7'b0, int_n}, 8'h01);

        // Reset in the middle of activity
        cfg_wr(4'd0, 8'd3);
        pulse(4'h1);
        pulse(4'h1);
        pulse(4'h2);
        pulse(4'h4);
        src  = 4'hF;
        iack = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iack  = 1'b0;
        check("midrst_int_n", {7'b0, int_n}, 8'h01);
        check("midrst_vec", vec, 8'hFF);
        tick();
        cfg_wr(4'd4, 8'h0F);
        tick();
        tick();
        check("held_src_quiet", {7'b0, int_n}, 8'h01);
        src = 4'h0;
        tick();
        cfg_wr(4'd0, 8'd2);
        pulse(4'h1);
        pulse(4'h1);
        check("cnt_cleared_quiet", {7'b0, int_n}, 8'h01);
        pulse(4'h1);
        check("cnt_cleared_fire", {7'b0, int_n}, 8'h00);
        do_ack();
        check("post_rst_vec", vec, 8'h00);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            src    = 4'($urandom_range(0, 15));
            iack   = ($urandom_range(0, 3) == 0);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_addr = 4'($urandom_range(0, 7));
            if (cfg_addr < 4'd4) cfg_data = 8'($urandom_range(0, 3));
            else cfg_data = 8'($urandom_range(0, 255));
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset  = 1'b0;
        cfg_we = 1'b0;
        iack   = 1'b0;
        src    = 4'h0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
